// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the fetch stage
package cpu_fetch_pkg;

    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam logic [15:0] PC_INCR    = 16'd2;
    localparam logic [3:0]  HLT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_INSTR  = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] pc_curr;
        logic [15:0] pc_next;
        logic [15:0] instr;
        logic        pred_taken;
        logic [15:0] pred_target;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, flush and hold
module if_id_reg
    import cpu_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;
    if_id_t q_d;

    // Next value: flush inserts an all-zero bubble (NOP, invalid), load
    // captures the fetched slot, otherwise the register holds.
    always_comb begin
        q_d = q_q;
        if (flush_i) begin
            q_d       = '0;
            q_d.instr = NOP_INSTR;
        end else if (load_i) begin
            q_d = d_i;
        end
    end

    // State register, cleared asynchronously so IF/ID is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC generator, halt FSM and IF/ID register
module fetch_pc_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC_P   = RESET_PC,
    parameter logic [15:0] PC_INCR_P    = PC_INCR,
    parameter logic [3:0]  HLT_OPCODE_P = HLT_OPCODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        predicted_taken,
    input  logic [15:0] predicted_target,
    input  logic        stall,
    input  logic        branch_mispredicted,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    output logic [15:0] PC_curr,
    output logic        dbp_enable,
    output logic [15:0] IF_ID_PC_curr,
    output logic [15:0] IF_ID_PC_next,
    output logic [15:0] IF_ID_instr,
    output logic        IF_ID_predicted_taken,
    output logic [15:0] IF_ID_predicted_target,
    output logic        IF_ID_valid,
    output logic        halted
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         load, flush;
    logic [15:0]  pc_plus;
    if_id_t       if_id_d, if_id_q;

    assign pc_plus = pc_q + PC_INCR_P;

    // Slot presented to IF/ID on a normal load.
    always_comb begin
        if_id_d             = '0;
        if_id_d.pc_curr     = pc_q;
        if_id_d.pc_next     = pc_plus;
        if_id_d.instr       = instr;
        if_id_d.pred_taken  = predicted_taken;
        if_id_d.pred_target = predicted_target;
        if_id_d.valid       = 1'b1;
    end

    // Next-PC priority and halt FSM: stall > mispredict > halt > predict > +2.
    // A stalled decode outcome is not trusted, so stall masks everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        if (stall) begin
            // hold everything
        end else if (branch_mispredicted) begin
            pc_d    = actual_taken ? actual_target : if_id_q.pc_next;
            flush   = 1'b1;
            state_d = RUN;
        end else if (state_q == HALT) begin
            flush = 1'b1;
        end else if (instr[15:12] == HLT_OPCODE_P) begin
            state_d = HALT;
            load    = 1'b1;
        end else if (predicted_taken) begin
            pc_d = predicted_target;
            load = 1'b1;
        end else begin
            pc_d = pc_plus;
            load = 1'b1;
        end
    end

    // PC and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC_P;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .flush_i (flush),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    assign PC_curr                = pc_q;
    assign halted                 = (state_q == HALT);
    assign dbp_enable             = ~stall & ~halted;
    assign IF_ID_PC_curr          = if_id_q.pc_curr;
    assign IF_ID_PC_next          = if_id_q.pc_next;
    assign IF_ID_instr            = if_id_q.instr;
    assign IF_ID_predicted_taken  = if_id_q.pred_taken;
    assign IF_ID_predicted_target = if_id_q.pred_target;
    assign IF_ID_valid            = if_id_q.valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        predicted_taken;
    logic [15:0] predicted_target;
    logic        stall;
    logic        branch_mispredicted;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic [15:0] PC_curr;
    logic        dbp_enable;
    logic [15:0] IF_ID_PC_curr;
    logic [15:0] IF_ID_PC_next;
    logic [15:0] IF_ID_instr;
    logic        IF_ID_predicted_taken;
    logic [15:0] IF_ID_predicted_target;
    logic        IF_ID_valid;
    logic        halted;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .instr                  (instr),
        .predicted_taken        (predicted_taken),
        .predicted_target       (predicted_target),
        .stall                  (stall),
        .branch_mispredicted    (branch_mispredicted),
        .actual_taken           (actual_taken),
        .actual_target          (actual_target),
        .PC_curr                (PC_curr),
        .dbp_enable             (dbp_enable),
        .IF_ID_PC_curr          (IF_ID_PC_curr),
        .IF_ID_PC_next          (IF_ID_PC_next),
        .IF_ID_instr            (IF_ID_instr),
        .IF_ID_predicted_taken  (IF_ID_predicted_taken),
        .IF_ID_predicted_target (IF_ID_predicted_target),
        .IF_ID_valid            (IF_ID_valid),
        .halted                 (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr = 16'h1234; predicted_taken = 1'b0; predicted_target = 16'h0;
        stall = 1'b0; branch_mispredicted = 1'b0; actual_taken = 1'b0; actual_target = 16'h0;
        step(); step();
        total_cnt++; if (PC_curr !== 16'h0000) $display("FAIL rst_pc got %h exp 0000", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", IF_ID_valid); else pass_cnt++;
        total_cnt++; if (IF_ID_instr !== 16'h0000) $display("FAIL rst_instr got %h exp 0000", IF_ID_instr); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted got %b exp 0", halted); else pass_cnt++;
        total_cnt++; if (dbp_enable !== 1'b1) $display("FAIL rst_dbp got %b exp 1", dbp_enable); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        step();
        total_cnt++; if (PC_curr !== 16'h0002) $display("FAIL seq_pc1 got %h exp 0002", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_PC_curr !== 16'h0000) $display("FAIL seq_ifid_pc1 got %h exp 0000", IF_ID_PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_PC_next !== 16'h0002) $display("FAIL seq_ifid_next1 got %h exp 0002", IF_ID_PC_next); else pass_cnt++;
        total_cnt++; if (IF_ID_valid !== 1'b1) $display("FAIL seq_valid1 got %b exp 1", IF_ID_valid); else pass_cnt++;
        total_cnt++; if (IF_ID_instr !== 16'h1234) $display("FAIL seq_instr1 got %h exp 1234", IF_ID_instr); else pass_cnt++;
        step();
        total_cnt++; if (PC_curr !== 16'h0004) $display("FAIL seq_pc2 got %h exp 0004", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_PC_curr !== 16'h0002) $display("FAIL seq_ifid_pc2 got %h exp 0002", IF_ID_PC_curr); else pass_cnt++;
    endtask

    task automatic test_predicted_taken();
        predicted_taken = 1'b1; predicted_target = 16'h0040;
        step();
        predicted_taken = 1'b0; predicted_target = 16'h0000;
        total_cnt++; if (PC_curr !== 16'h0040) $display("FAIL pred_pc got %h exp 0040", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_predicted_taken !== 1'b1) $display("FAIL pred_taken got %b exp 1", IF_ID_predicted_taken); else pass_cnt++;
        total_cnt++; if (IF_ID_predicted_target !== 16'h0040) $display("FAIL pred_target got %h exp 0040", IF_ID_predicted_target); else pass_cnt++;
        total_cnt++; if (IF_ID_PC_curr !== 16'h0004) $display("FAIL pred_ifid_pc got %h exp 0004", IF_ID_PC_curr); else pass_cnt++;
        step();
        total_cnt++; if (IF_ID_PC_curr !== 16'h0040) $display("FAIL pred_ifid_pc2 got %h exp 0040", IF_ID_PC_curr); else pass_cnt++;
        total_cnt++; if (PC_curr !== 16'h0042) $display("FAIL pred_pc2 got %h exp 0042", PC_curr); else pass_cnt++;
    endtask

    task automatic test_mispredict_not_taken();
        // IF/ID holds 0x0040; redirect to its fall-through 0x0042
        branch_mispredicted = 1'b1; actual_taken = 1'b0; actual_target = 16'h0080;
        step();
        branch_mispredicted = 1'b0;
        total_cnt++; if (PC_curr !== 16'h0042) $display("FAIL mis_nt_pc got %h exp 0042", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL mis_nt_valid got %b exp 0", IF_ID_valid); else pass_cnt++;
        total_cnt++; if (IF_ID_instr !== 16'h0000) $display("FAIL mis_nt_instr got %h exp 0000", IF_ID_instr); else pass_cnt++;
    endtask

    task automatic test_stall_over_mispredict();
        step();
        total_cnt++; if (PC_curr !== 16'h0044) $display("FAIL stl_pre_pc got %h exp 0044", PC_curr); else pass_cnt++;
        stall = 1'b1; branch_mispredicted = 1'b1; actual_taken = 1'b1; actual_target = 16'h0100;
        #1;
        total_cnt++; if (dbp_enable !== 1'b0) $display("FAIL stl_dbp got %b exp 0", dbp_enable); else pass_cnt++;
        step(); step();
        total_cnt++; if (PC_curr !== 16'h0044) $display("FAIL stl_pc got %h exp 0044", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_PC_curr !== 16'h0042) $display("FAIL stl_ifid_pc got %h exp 0042", IF_ID_PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_valid !== 1'b1) $display("FAIL stl_valid got %b exp 1", IF_ID_valid); else pass_cnt++;
        total_cnt++; if (IF_ID_instr !== 16'h1234) $display("FAIL stl_instr got %h exp 1234", IF_ID_instr); else pass_cnt++;
        stall = 1'b0;
        step();
        branch_mispredicted = 1'b0;
        total_cnt++; if (PC_curr !== 16'h0100) $display("FAIL stl_rel_pc got %h exp 0100", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL stl_rel_valid got %b exp 0", IF_ID_valid); else pass_cnt++;
    endtask

    task automatic test_halt_release();
        branch_mispredicted = 1'b1; actual_taken = 1'b1; actual_target = 16'h0008;
        step();
        branch_mispredicted = 1'b0;
        total_cnt++; if (PC_curr !== 16'h0008) $display("FAIL hlt_pre_pc got %h exp 0008", PC_curr); else pass_cnt++;
        instr = 16'hF000;
        step();
        total_cnt++; if (halted !== 1'b1) $display("FAIL hlt_halted got %b exp 1", halted); else pass_cnt++;
        total_cnt++; if (PC_curr !== 16'h0008) $display("FAIL hlt_pc got %h exp 0008", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_instr !== 16'hF000) $display("FAIL hlt_ifid_instr got %h exp f000", IF_ID_instr); else pass_cnt++;
        total_cnt++; if (IF_ID_valid !== 1'b1) $display("FAIL hlt_ifid_valid got %b exp 1", IF_ID_valid); else pass_cnt++;
        total_cnt++; if (dbp_enable !== 1'b0) $display("FAIL hlt_dbp got %b exp 0", dbp_enable); else pass_cnt++;
        step();
        total_cnt++; if (PC_curr !== 16'h0008) $display("FAIL hlt_hold_pc got %h exp 0008", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL hlt_bubble_valid got %b exp 0", IF_ID_valid); else pass_cnt++;
        total_cnt++; if (IF_ID_instr !== 16'h0000) $display("FAIL hlt_bubble_instr got %h exp 0000", IF_ID_instr); else pass_cnt++;
        branch_mispredicted = 1'b1; actual_taken = 1'b1; actual_target = 16'h0010;
        step();
        branch_mispredicted = 1'b0; instr = 16'h1234;
        total_cnt++; if (halted !== 1'b0) $display("FAIL hlt_rel_halted got %b exp 0", halted); else pass_cnt++;
        total_cnt++; if (PC_curr !== 16'h0010) $display("FAIL hlt_rel_pc got %h exp 0010", PC_curr); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        instr = 16'hF123;
        step();
        instr = 16'h1234;
        total_cnt++; if (halted !== 1'b1) $display("FAIL ars_pre_halted got %b exp 1", halted); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (halted !== 1'b0) $display("FAIL ars_halted got %b exp 0", halted); else pass_cnt++;
        total_cnt++; if (PC_curr !== 16'h0000) $display("FAIL ars_pc got %h exp 0000", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_PC_curr !== 16'h0000) $display("FAIL ars_ifid_pc got %h exp 0000", IF_ID_PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_instr !== 16'h0000) $display("FAIL ars_ifid_instr got %h exp 0000", IF_ID_instr); else pass_cnt++;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_and_self_loop();
        branch_mispredicted = 1'b1; actual_taken = 1'b1; actual_target = 16'hFFFE;
        step();
        branch_mispredicted = 1'b0;
        total_cnt++; if (PC_curr !== 16'hFFFE) $display("FAIL wrap_pre_pc got %h exp fffe", PC_curr); else pass_cnt++;
        step();
        total_cnt++; if (PC_curr !== 16'h0000) $display("FAIL wrap_pc got %h exp 0000", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_PC_next !== 16'h0000) $display("FAIL wrap_ifid_next got %h exp 0000", IF_ID_PC_next); else pass_cnt++;
        predicted_taken = 1'b1; predicted_target = 16'h0000;
        step();
        predicted_taken = 1'b0;
        total_cnt++; if (PC_curr !== 16'h0000) $display("FAIL loop_pc got %h exp 0000", PC_curr); else pass_cnt++;
        total_cnt++; if (IF_ID_valid !== 1'b1) $display("FAIL loop_valid got %b exp 1", IF_ID_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_predicted_taken();
        test_mispredict_not_taken();
        test_stall_over_mispredict();
        test_halt_release();
        test_async_reset();
        test_wrap_and_self_loop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
